data_mem_responder: RTL and testbench

Multi-cycle responder for the datapath's 64-bit load/store port. It replaces the zero-latency data memory with a handshaked target: it accepts one request, waits a fixed access latency, performs the access on a big-endian byte array, and returns a response. It sits between the memory-stage initiator and the data storage. Each access produces exactly one response.

---
 rtl/mem_resp_pkg.sv | 8 +
 rtl/mem_byte_array.sv | 21 ++
 rtl/data_mem_responder.sv | 69 ++++++
 tb/tb_data_mem_responder.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/mem_resp_pkg.sv
// mem_resp_pkg: shared types, constants and address check for the data memory responder
package mem_resp_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam logic [63:0] RDATA_ERR = 64'h0;
  function automatic logic addr_err(input logic [63:0] a, input logic [63:0] depth);
    return (a[2:0] != 3'd0) || (a > depth - 64'd8);
  endfunction
endpackage

// File: rtl/mem_byte_array.sv
// mem_byte_array: byte storage with one 8-byte big-endian read/write port
module mem_byte_array #(
  parameter int DEPTH_BYTES = 1024,
  parameter int AW = $clog2(DEPTH_BYTES)
) (
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);
  logic [7:0] mem [DEPTH_BYTES];
  // lowest address lands in the most significant byte
  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) rdata[63-8*i -: 8] = mem[addr + AW'(i)];
  end
  // all eight bytes written together on the commit edge
  always_ff @(posedge CLK)
    if (we) for (int i = 0; i < 8; i++) mem[addr + AW'(i)] <= wdata[63-8*i -: 8];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: handshaked fixed-latency target for the 64-bit load/store port
module data_mem_responder import mem_resp_pkg::*; #(
  parameter int DEPTH_BYTES = 1024,
  parameter int LATENCY = 3
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int CW = $clog2(LATENCY + 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic wr_q, err_q, accept, commit, we;
  logic [AW-1:0] addr_q;
  logic [63:0] wdata_q, rd;
  assign accept = req_valid && req_ready;
  assign commit = state == WAIT && cnt == '0;
  // next state and storage write enable; a reset on the commit edge blocks the write
  always_comb begin
    state_n = state == IDLE ? (accept ? WAIT : IDLE) :
              state == WAIT ? (commit ? RESP : WAIT) :
              (resp_ready ? IDLE : RESP);
    we = commit && wr_q && !err_q && !reset;
  end
  // state and registered outputs, response captured on the commit edge
  always_ff @(posedge CLK) begin
    if (reset) begin
      state <= IDLE;
      req_ready <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= RDATA_ERR;
      resp_err <= 1'b0;
    end else begin
      state <= state_n;
      req_ready <= state_n == IDLE;
      resp_valid <= state_n == RESP;
      if (commit) begin
        resp_rdata <= (wr_q || err_q) ? RDATA_ERR : rd;
        resp_err <= err_q;
      end
    end
  end
  // latch the request at accept and count down the access latency
  always_ff @(posedge CLK) begin
    if (accept) begin
      wr_q <= req_write;
      err_q <= addr_err(req_addr, 64'(DEPTH_BYTES));
      addr_q <= req_addr[AW-1:0];
      wdata_q <= req_wdata;
      cnt <= CW'(LATENCY - 1);
    end else if (state == WAIT && cnt != '0) cnt <= cnt - 1'b1;
  end
  mem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES)) u_mem (
    .CLK(CLK),
    .we(we),
    .addr(addr_q),
    .wdata(wdata_q),
    .rdata(rd)
  );
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed plus random checks against a byte-array reference model
module tb_data_mem_responder;
  localparam int DEPTH = 1024;
  localparam int LAT = 3;
  logic CLK = 1'b0;
  logic reset = 1'b1;
  always #5 CLK = ~CLK;
  logic req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic req_ready, resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic v1 = 1'b0, w1 = 1'b1;
  logic [63:0] a1 = 64'h100, d1 = '0;
  logic r1, rv1, e1;
  logic [63:0] q1;
  int errors = 0, checks = 0, cyc = 0;
  logic [7:0] model [DEPTH];
  logic [63:0] last_rdata;
  logic last_err;

  always @(posedge CLK) cyc++;

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) u0 (
    .CLK(CLK), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(1)) u1 (
    .CLK(CLK), .reset(reset), .req_valid(v1), .req_ready(r1),
    .req_write(w1), .req_addr(a1), .req_wdata(d1),
    .resp_valid(rv1), .resp_ready(1'b1), .resp_rdata(q1), .resp_err(e1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic ref_err(input logic [63:0] a);
    return (a % 64'd8 != 0) || (a / 64'd8 >= 64'(DEPTH / 8));
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a);
    logic [63:0] d = '0;
    for (int i = 0; i < 8; i++) d = {d[55:0], model[int'(a) + i]};
    return d;
  endfunction

  task automatic ref_store(input logic [63:0] a, input logic [63:0] d);
    for (int i = 0; i < 8; i++) model[int'(a) + i] = d[63-8*i -: 8];
  endtask

  // one full transaction on u0, called at a negedge; hold = cycles of response backpressure
  task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d, input int hold, input string tag);
    int k;
    logic e;
    logic [63:0] x;
    e = ref_err(a);
    x = (w || e) ? 64'h0 : ref_load(a);
    k = 0;
    while (!req_ready && k < 20) begin @(negedge CLK); k++; end
    chk({tag, " req_ready idle"}, 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    resp_ready = (hold == 0);
    @(negedge CLK);
    req_valid = 1'b0; req_write = 1'($urandom); req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    chk({tag, " req_ready busy"}, 64'(req_ready), 64'd0);
    k = 0;
    while (!resp_valid && k < 20) begin @(negedge CLK); k++; end
    if (w && !e) ref_store(a, d);
    chk({tag, " latency"}, 64'(k), 64'(LAT));
    chk({tag, " rdata"}, resp_rdata, x);
    chk({tag, " err"}, 64'(resp_err), 64'(e));
    last_rdata = resp_rdata;
    last_err = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(negedge CLK);
      chk({tag, " hold valid"}, 64'(resp_valid), 64'd1);
      chk({tag, " hold rdata"}, resp_rdata, x);
      chk({tag, " hold err"}, 64'(resp_err), 64'(e));
      chk({tag, " hold req_ready"}, 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(negedge CLK);
    chk({tag, " consumed"}, 64'(resp_valid), 64'd0);
    chk({tag, " ready again"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    int acc[$];
    int rc, sel;
    logic pend;
    logic [63:0] a;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;

    @(negedge CLK);
    @(negedge CLK);
    chk("reset req_ready", 64'(req_ready), 64'd0);
    chk("reset resp_valid", 64'(resp_valid), 64'd0);
    reset = 1'b0;
    @(negedge CLK);
    chk("idle req_ready", 64'(req_ready), 64'd1);
    chk("idle resp_valid", 64'(resp_valid), 64'd0);
    chk("idle resp_rdata", resp_rdata, 64'd0);
    chk("idle resp_err", 64'(resp_err), 64'd0);
    chk("idle u1 req_ready", 64'(r1), 64'd1);

    do_req(1'b1, 64'd16, 64'h0123456789ABCDEF, 0, "st16");
    do_req(1'b0, 64'd16, 64'h0, 0, "ld16");
    chk("ld16 value", last_rdata, 64'h0123456789ABCDEF);
    chk("ld16 byte16", 64'(last_rdata[63:56]), 64'h01);
    chk("ld16 byte23", 64'(last_rdata[7:0]), 64'hEF);

    do_req(1'b0, 64'd16, 64'h0, 5, "bp");

    do_req(1'b0, 64'd12, 64'h0, 0, "misaligned");
    chk("misaligned err", 64'(last_err), 64'd1);
    do_req(1'b1, 64'(DEPTH - 8), 64'h1122334455667788, 0, "st top");
    do_req(1'b1, 64'(DEPTH - 4), 64'hA5A5A5A5A5A5A5A5, 0, "st oob");
    chk("oob err", 64'(last_err), 64'd1);
    do_req(1'b0, 64'(DEPTH - 8), 64'h0, 0, "ld top");
    chk("top unchanged", last_rdata, 64'h1122334455667788);
    do_req(1'b0, 64'hFFFFFFFFFFFFFFF8, 64'h0, 0, "wrap");
    chk("wrap err", 64'(last_err), 64'd1);

    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd0; req_wdata = 64'hDEADBEEF00000000;
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    chk("rst wait req_ready", 64'(req_ready), 64'd0);
    chk("rst wait resp_valid", 64'(resp_valid), 64'd0);
    reset = 1'b0;
    @(negedge CLK);
    chk("rst wait resp_valid after", 64'(resp_valid), 64'd0);
    do_req(1'b0, 64'd0, 64'h0, 0, "ld0 after wait rst");
    chk("ld0 unchanged", last_rdata, 64'h0);

    resp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd0; req_wdata = 64'hDEADBEEF00000000;
    @(negedge CLK);
    req_valid = 1'b0;
    rc = 0;
    while (!resp_valid && rc < 20) begin @(negedge CLK); rc++; end
    chk("rst resp latency", 64'(rc), 64'(LAT));
    ref_store(64'd0, 64'hDEADBEEF00000000);
    reset = 1'b1;
    @(negedge CLK);
    chk("rst resp resp_valid", 64'(resp_valid), 64'd0);
    reset = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      chk("no stale resp_valid", 64'(resp_valid), 64'd0);
    end
    do_req(1'b0, 64'd0, 64'h0, 0, "ld0 after resp rst");
    chk("ld0 persisted", last_rdata, 64'hDEADBEEF00000000);

    for (int n = 0; n < 40; n++) begin
      sel = int'($urandom_range(0, 9));
      a = sel < 7 ? 64'($urandom_range(0, 15)) * 64'd8 :
          sel == 7 ? 64'($urandom_range(0, 127)) :
          sel == 8 ? 64'(DEPTH - 8) : {$urandom, $urandom};
      do_req(1'($urandom_range(0, 1)), a, {$urandom, $urandom}, int'($urandom_range(0, 2)), "rnd");
    end

    rc = 0;
    pend = 1'b0;
    d1 = {$urandom, $urandom};
    v1 = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (pend) begin a1 = a1 + 64'd8; d1 = {$urandom, $urandom}; pend = 1'b0; end
      if (rv1) begin
        rc++;
        chk("lat1 err", 64'(e1), 64'd0);
        chk("lat1 rdata", q1, 64'd0);
      end
      if (r1) begin acc.push_back(cyc + 1); pend = 1'b1; end
      @(negedge CLK);
    end
    v1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rv1) rc++;
      @(negedge CLK);
    end
    chk("lat1 accepts", 64'(acc.size() >= 4), 64'd1);
    for (int i = 1; i < acc.size(); i++) chk("lat1 spacing", 64'(acc[i] - acc[i-1]), 64'd3);
    chk("lat1 responses", 64'(rc), 64'(acc.size()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
